rr_sel_arbiter: RTL and testbench
=================================

// Module: rr_sel_arbiter
// PURPOSE
//  Round-robin arbiter that sits directly upstream of the priority-case select decoder.
//  Arbitrates NUM_REQ request lines and produces the registered binary index sel, which
//  feeds the decoder's sel input, plus a matching one-hot gnt.
//  sel is never X/Z after reset, so the downstream priority case never hits a no-match.
//  A hold-limit counter forces rotation when an owner keeps its request high too long.
// PARAMETERS
//  NUM_REQ   4   number of requesters; must be 4 when driving the 2-bit decoder
//  MAX_HOLD  8   max consecutive grant cycles per owner while others wait; 0 = unlimited
// PORTS
//  clk        in   1              single clock, rising edge
//  rst        in   1              asynchronous, active-high reset
//  req        in   NUM_REQ        request per requester; level, held until served
//  sel        out  $clog2(NUM_REQ) registered index of current or last owner -> decoder sel
//  sel_valid  out  1              high while a grant is active
//  gnt        out  NUM_REQ        registered one-hot grant; all-zero when sel_valid=0
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert):
//   - Outputs: sel=0, sel_valid=0, gnt=0.
//   - Internal: state=IDLE, ptr=0 (next-priority index), hold_cnt=0.
//  Round-robin pick:
//   - Search req starting at ptr and wrapping modulo NUM_REQ; the first set bit wins.
//  FSM: states IDLE and GRANT.
//   IDLE:
//    - If req==0, stay in IDLE; sel holds its last value.
//    - If req!=0, pick winner w; at the next edge: gnt=1<<w, sel=w, sel_valid=1, hold_cnt=0,
//      state=GRANT. Latency is 1 cycle from req to gnt.
//   GRANT (owner o):
//    - Release (req[o]==0): ptr=o+1 (wrapped). If other requests are pending, re-pick from
//      o+1 and switch gnt at the next edge (back-to-back, no idle cycle). Otherwise go to
//      IDLE with gnt=0 and sel_valid=0.
//    - Preempt (req[o]==1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, any other req set): ptr=o+1
//      and re-pick, excluding o. Ownership moves at the next edge. o re-enters in RR order.
//    - Hold otherwise: keep o. hold_cnt increments and saturates at MAX_HOLD-1. With no
//      other requester, o may hold indefinitely.
//  Invariants:
//   - gnt is one-hot or zero.
//   - When sel_valid=1, gnt==(1<<sel).
//   - sel changes only at an edge where a new grant is issued.
//  Boundaries:
//   - Simultaneous release and new request by the same o: treated as release. o is lowest
//     priority for that pick and is re-granted only if it is the sole requester.
//   - ptr wrap: 3 -> 0.
//   - Reset mid-grant: gnt drops immediately (async). Arbitration restarts from ptr=0.
//   - X/Z on req bits: those bits are treated as 0. An assertion flags them in simulation.
// STRUCTURE
//  Shared package arb_pkg:
//   - typedef enum logic {IDLE, GRANT} arb_state_t
//   - localparam SEL_W=$clog2(NUM_REQ)
//   - typedef logic [SEL_W-1:0] sel_t
//  Sub-module rr_pick (combinational):
//   - Inputs: req, ptr, excl_en, excl_idx.
//   - Outputs: found, idx. Uses a doubled-vector rotate-and-priority-encode.
//  Top level holds the FSM, ptr, hold_cnt and the output registers, plus SVA for:
//   - one-hot gnt
//   - gnt/sel consistency
//   - no X on sel after reset
// TESTING
//  1 Reset: assert rst mid-run while gnt=0100 -> gnt=0, sel=0, sel_valid=0 with no clock edge.
//  2 Single request: req=0010 at cycle N -> gnt=0010, sel=01, sel_valid=1 at N+1.
//    Drop req -> gnt=0 next cycle; sel stays 01.
//  3 Rotation: req=1111, each owner drops req after 1 grant cycle -> sel sequence 00,01,10,11,00.
//    No idle cycles between grants.
//  4 Preemption (MAX_HOLD=8): req[0] held, req[2] asserted at grant start -> gnt moves
//    0001 -> 0100 after exactly 8 grant cycles.
//  5 Solo hold: only req[3] held for 20 cycles -> gnt=1000 throughout, no preemption.
//  6 Decoder chain: connect sel to the priority-case decoder and run test 3 -> decoder out is
//    0001,0010,0100,1000. No priority-case violation warnings after reset.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : arb_pkg                                                    |
// | Brief   : Shared types and constants for the round-robin arbiter.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int NUM_REQ_DFLT = 4;
  localparam int SEL_W        = $clog2(NUM_REQ_DFLT);

  typedef logic [SEL_W-1:0] sel_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_pick                                                    |
// | Brief   : Combinational round-robin pick starting at ptr, with an    |
// |           optional excluded index.                                   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DFLT,
  parameter int SW      = SEL_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SW-1:0]      ptr,
  input  logic               excl_en,
  input  logic [SW-1:0]      excl_idx,
  output logic               found,
  output logic [SW-1:0]      idx
);

  localparam logic [SW:0] C_NUM = (SW+1)'(NUM_REQ);

  logic [NUM_REQ-1:0]   w_masked;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SW:0]          w_off;
  logic [SW:0]          w_sum;

  always_comb begin
    w_masked = req;
    if (excl_en) w_masked[excl_idx] = 1'b0;
  end

  // Rotating the doubled vector puts ptr at bit 0, so the lowest set bit wins.
  assign w_dbl = {w_masked, w_masked} >> ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];

  always_comb begin
    found = 1'b0;
    w_off = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (w_rot[i]) begin
        found = 1'b1;
        w_off = (SW+1)'(i);
      end
    end
    w_sum = {1'b0, ptr} + w_off;
    idx   = (w_sum >= C_NUM) ? SW'(w_sum - C_NUM) : SW'(w_sum);
  end

endmodule
`default_nettype wire

// File: rtl/rr_sel_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_sel_arbiter                                             |
// | Brief   : Round-robin arbiter with hold limit; registered sel/gnt    |
// |           feeding the downstream select decoder.                     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_sel_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [$clog2(NUM_REQ)-1:0] sel,
  output logic                       sel_valid,
  output logic [NUM_REQ-1:0]         gnt
);

  localparam int               SW         = $clog2(NUM_REQ);
  localparam int               HW         = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]    C_HOLD_MAX = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [SW-1:0]    C_LAST     = SW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] C_ONE    = NUM_REQ'(1);

  arb_state_t         r_state;
  logic [SW-1:0]      r_ptr;
  logic [SW-1:0]      r_sel;
  logic [HW-1:0]      r_hold;
  logic               r_valid;
  logic [NUM_REQ-1:0] r_gnt;

  logic [NUM_REQ-1:0] w_req;
  logic [SW-1:0]      w_next_ptr;
  logic [SW-1:0]      w_pick_ptr;
  logic               w_in_grant;
  logic               w_owner_req;
  logic               w_hold_max;
  logic               w_found;
  logic [SW-1:0]      w_idx;

  // Unknown request bits count as idle so sel can never go X.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) w_req[i] = (req[i] === 1'b1);
  end

  assign w_in_grant  = (r_state == GRANT);
  assign w_owner_req = w_req[r_sel];
  assign w_next_ptr  = (r_sel == C_LAST) ? '0 : r_sel + 1'b1;
  assign w_pick_ptr  = w_in_grant ? w_next_ptr : r_ptr;
  assign w_hold_max  = (MAX_HOLD != 0) && (r_hold == C_HOLD_MAX);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SW      (SW)
  ) u_pick (
    .req      (w_req),
    .ptr      (w_pick_ptr),
    .excl_en  (w_in_grant),
    .excl_idx (r_sel),
    .found    (w_found),
    .idx      (w_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_hold  <= '0;
      r_valid <= 1'b0;
      r_gnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= GRANT;
            r_sel   <= w_idx;
            r_gnt   <= C_ONE << w_idx;
            r_valid <= 1'b1;
            r_hold  <= '0;
          end
        end
        GRANT: begin
          if (!w_owner_req || (w_hold_max && w_found)) begin
            r_ptr <= w_next_ptr;
            if (w_found) begin
              r_sel  <= w_idx;
              r_gnt  <= C_ONE << w_idx;
              r_hold <= '0;
            end else begin
              r_state <= IDLE;
              r_gnt   <= '0;
              r_valid <= 1'b0;
              r_hold  <= '0;
            end
          end else if (MAX_HOLD != 0 && r_hold != C_HOLD_MAX) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sel       = r_sel;
  assign sel_valid = r_valid;
  assign gnt       = r_gnt;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt))
    else $error("gnt not one-hot: %b", r_gnt);
  a_gnt_sel: assert property (@(posedge clk) disable iff (rst)
                              r_valid ? (r_gnt == (C_ONE << r_sel)) : (r_gnt == '0))
    else $error("gnt/sel inconsistent: gnt=%b sel=%0d", r_gnt, r_sel);
  a_sel_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(r_sel))
    else $error("sel unknown after reset");
  a_req_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(req))
    else $error("req has X/Z bits: %b", req);

endmodule
`default_nettype wire

// File: tb/tb_rr_sel_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_rr_sel_arbiter                                          |
// | Brief   : Self-checking bench for rr_sel_arbiter with a reference    |
// |           model of the round-robin/hold-limit rules.                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_rr_sel_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [1:0]   sel;
  logic         sel_valid;
  logic [N-1:0] gnt;

  int errors = 0;
  int checks = 0;

  int m_valid, m_sel, m_ptr, m_hold;

  always #5 clk = ~clk;

  rr_sel_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .sel       (sel),
    .sel_valid (sel_valid),
    .gnt       (gnt)
  );

  function automatic int first_from(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_sel = 0; m_ptr = 0; m_hold = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    logic [N-1:0] others;
    int o;
    if (m_valid == 0) begin
      if (r != '0) begin
        m_sel = first_from(r, m_ptr); m_valid = 1; m_hold = 0;
      end
    end else begin
      o = m_sel;
      others = r;
      others[o] = 1'b0;
      if (!r[o]) begin
        m_ptr = (o + 1) % N;
        if (others != '0) begin m_sel = first_from(others, m_ptr); m_hold = 0; end
        else begin m_valid = 0; m_hold = 0; end
      end else if (MH != 0 && m_hold == MH - 1 && others != '0) begin
        m_ptr = (o + 1) % N;
        m_sel = first_from(others, m_ptr);
        m_hold = 0;
      end else if (m_hold < MH - 1) begin
        m_hold++;
      end
    end
  endtask

  function automatic logic [2+N:0] model_out();
    logic [N-1:0] g;
    g = '0;
    if (m_valid != 0) g[m_sel] = 1'b1;
    return {(m_valid != 0), 2'(m_sel), g};
  endfunction

  task automatic drive(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    model_step(r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    model_reset();
    #2;
    checks++;
    if ({sel_valid, sel, gnt} !== 7'b0) begin
      errors++;
      $display("FAIL reset_initial: got valid=%b sel=%0d gnt=%b, want 0/0/0000", sel_valid, sel, gnt);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0100);
    drive(4'b0100);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL reset_pregrant: gnt=%b want 0100", gnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({sel_valid, sel, gnt} !== 7'b0) begin
      errors++;
      $display("FAIL reset_async: got valid=%b sel=%0d gnt=%b, want 0/0/0000", sel_valid, sel, gnt);
    end
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    model_reset();
  endtask

  task automatic test_single();
    drive(4'b0000);
    drive(4'b0010);
    checks++;
    if ({sel_valid, sel, gnt} !== {1'b1, 2'b01, 4'b0010}) begin
      errors++;
      $display("FAIL single_grant: got valid=%b sel=%0d gnt=%b, want 1/1/0010", sel_valid, sel, gnt);
    end
    drive(4'b0000);
    checks++;
    if ({sel_valid, sel, gnt} !== {1'b0, 2'b01, 4'b0000}) begin
      errors++;
      $display("FAIL single_release: got valid=%b sel=%0d gnt=%b, want 0/1/0000", sel_valid, sel, gnt);
    end
  endtask

  task automatic test_rotation();
    int seq[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] r;
    logic [N-1:0] dec;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      r = 4'b1111;
      if (k > 0) r[seq[k-1]] = 1'b0;
      drive(r);
      dec = '0;
      dec[seq[k]] = 1'b1;
      checks++;
      if ({sel_valid, sel, gnt} !== {1'b1, 2'(seq[k]), dec}) begin
        errors++;
        $display("FAIL rotation_step%0d: got valid=%b sel=%0d gnt=%b, want 1/%0d/%b",
                 k, sel_valid, sel, gnt, seq[k], dec);
      end
      checks++;
      if (model_out() !== {sel_valid, sel, gnt}) begin
        errors++;
        $display("FAIL rotation_model%0d: got %b want %b", k, {sel_valid, sel, gnt}, model_out());
      end
    end
    drive(4'b0000);
  endtask

  task automatic test_preempt();
    do_reset();
    drive(4'b0001);
    for (int k = 1; k < MH; k++) begin
      drive(4'b0101);
      checks++;
      if (gnt !== 4'b0001) begin
        errors++;
        $display("FAIL preempt_hold%0d: gnt=%b want 0001", k, gnt);
      end
    end
    drive(4'b0101);
    checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2) begin
      errors++;
      $display("FAIL preempt_switch: gnt=%b sel=%0d want 0100/2", gnt, sel);
    end
    for (int k = 0; k < 12; k++) begin
      drive(4'b0101);
      checks++;
      if (model_out() !== {sel_valid, sel, gnt}) begin
        errors++;
        $display("FAIL preempt_model%0d: got %b want %b", k, {sel_valid, sel, gnt}, model_out());
      end
    end
    drive(4'b0000);
  endtask

  task automatic test_solo();
    for (int k = 0; k < 20; k++) begin
      drive(4'b1000);
      checks++;
      if ({sel_valid, sel, gnt} !== {1'b1, 2'd3, 4'b1000}) begin
        errors++;
        $display("FAIL solo_hold%0d: got valid=%b sel=%0d gnt=%b, want 1/3/1000", k, sel_valid, sel, gnt);
      end
    end
    drive(4'b0000);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] r;
    for (int k = 0; k < 400; k++) begin
      r = N'($urandom_range(0, 15));
      if (m_valid != 0 && $urandom_range(0, 3) != 0) r[m_sel] = 1'b1;
      if ($urandom_range(0, 15) == 0) r = '0;
      drive(r);
      checks++;
      if (model_out() !== {sel_valid, sel, gnt}) begin
        errors++;
        $display("FAIL random_cycle%0d: req=%b got %b want %b", k, r, {sel_valid, sel, gnt}, model_out());
      end
    end
    drive(4'b0000);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_preempt();
    test_solo();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
